// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: N-bit SAR controller; in adc_clk/adc_rst/go/cmp, out sample/dac_code/result/valid/busy (all registered)
module sar_adc_ctrl #(
  parameter int N = 5,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic         adc_clk,
  input  logic         adc_rst,
  input  logic         go,
  input  logic         cmp,
  output logic         sample,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] result,
  output logic         valid,
  output logic         busy
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, SAMP = 2'd1, CONV = 2'd2, DONE = 2'd3;
  logic [1:0] sync, state, state_n;
  logic [3:0] cnt;
  logic [IW-1:0] idx;
  logic [N-1:0] code_n;
  assign code_n = dac_code & ~({{(N-1){1'b0}}, !cmp} << idx);
  always_comb
    state_n = state == IDLE ? (sync[1] ? SAMP : IDLE) :
              state == SAMP ? (cnt == 4'(SAMPLE_CYCLES - 1) ? CONV : SAMP) :
              state == CONV ? (idx == '0 ? DONE : CONV) : IDLE;
  always_ff @(posedge adc_clk or posedge adc_rst)
    if (adc_rst) begin
      sync     <= '0;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      dac_code <= '0;
      result   <= '0;
      sample   <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sync   <= {sync[0], go};
      state  <= state_n;
      sample <= state_n == SAMP;
      valid  <= state_n == DONE;
      busy   <= state_n != IDLE;
      cnt    <= state == SAMP ? cnt + 4'd1 : 4'd0;
      if (state == SAMP && state_n == CONV) begin
        dac_code <= {1'b1, {(N-1){1'b0}}};
        idx      <= IW'(N - 1);
      end else if (state == CONV) begin
        dac_code <= idx == '0 ? code_n : code_n | ({{(N-1){1'b0}}, 1'b1} << (idx - IW'(1)));
        idx      <= idx == '0 ? idx : idx - IW'(1);
        if (idx == '0) result <= code_n;
      end else if (state == DONE) begin
        dac_code <= '0;
      end
    end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: timeline model + directed vectors for sar_adc_ctrl
module tb_sar_adc_ctrl;
  localparam int N = 5, S = 2, SB = 1;
  logic clk = 0, rst = 1;
  logic go_a = 0, go_b = 0;
  int vin_a = 0, vin_b = 0;
  logic cmp_a, cmp_b, sample_a, sample_b, valid_a, valid_b, busy_a, busy_b;
  logic [N-1:0] dac_a, dac_b, result_a, result_b;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  assign cmp_a = vin_a >= int'(dac_a);
  assign cmp_b = vin_b >= int'(dac_b);

  sar_adc_ctrl #(.N(N), .SAMPLE_CYCLES(S)) dut_a (
    .adc_clk(clk), .adc_rst(rst), .go(go_a), .cmp(cmp_a), .sample(sample_a),
    .dac_code(dac_a), .result(result_a), .valid(valid_a), .busy(busy_a));
  sar_adc_ctrl #(.N(N), .SAMPLE_CYCLES(SB)) dut_b (
    .adc_clk(clk), .adc_rst(rst), .go(go_b), .cmp(cmp_b), .sample(sample_b),
    .dac_code(dac_b), .result(result_b), .valid(valid_b), .busy(busy_b));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // binary search step k: trial code shown to the DAC; k == N gives the final code
  function automatic int bs(input int v, input int k);
    int c = 0;
    for (int b = N - 1; b >= N - k && b >= 0; b--)
      if (v >= (c | (1 << b))) c = c | (1 << b);
    return k < N ? c | (1 << (N - 1 - k)) : c;
  endfunction

  // timeline model of dut_a: ph = cycle within conversion, -1 when idle
  bit g1 = 0, g2 = 0;
  int ph = -1, mres = 0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      g1 <= 0; g2 <= 0; ph <= -1; mres <= 0;
    end else begin
      g1 <= go_a;
      g2 <= g1;
      ph <= ph < 0 ? (g2 ? 0 : -1) : ph == S + N ? -1 : ph + 1;
      if (ph == S + N - 1) mres <= bs(vin_a, N);
    end

  int vtimes[$], srise[$];
  bit prev_s = 0, prev_sb = 0;
  int nsb = 0, nvb = 0, tv_b = -1, tr_b = -1, rb = -1;
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk("sample", int'(sample_a), int'(ph >= 0 && ph < S));
      chk("busy", int'(busy_a), int'(ph >= 0));
      chk("valid", int'(valid_a), int'(ph == S + N));
      chk("dac_code", int'(dac_a), (ph >= S && ph <= S + N) ? bs(vin_a, ph - S) : 0);
      chk("result", int'(result_a), mres);
    end
    if (valid_a) vtimes.push_back(cyc);
    if (sample_a && !prev_s) srise.push_back(cyc);
    prev_s = sample_a;
    if (sample_b) nsb++;
    if (sample_b && !prev_sb) tr_b = cyc;
    if (valid_b) begin nvb++; tv_b = cyc; rb = int'(result_b); end
    prev_sb = sample_b;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 30 && !valid_a; i++) @(negedge clk);
    chk(name, int'(valid_a), 1);
  endtask

  int ends[2] = '{0, 31};
  int n0, nv;

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    chk("bs19_0", bs(19, 0), 16);
    chk("bs19_1", bs(19, 1), 24);
    chk("bs19_2", bs(19, 2), 20);
    chk("bs19_3", bs(19, 3), 18);
    chk("bs19_4", bs(19, 4), 19);
    chk("bs19_fin", bs(19, 5), 19);
    chk("bs0_4", bs(0, 4), 1);
    chk("bs31_3", bs(31, 3), 30);
    tick(3);
    chk("rst_dac", int'(dac_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    rst = 0;
    chk_en = 1;
    tick(2);
    // single conversion of 19
    vin_a = 19;
    go_a = 1;
    tick(3);
    go_a = 0;
    wait_valid("t1_valid_seen");
    chk("t1_result", int'(result_a), 19);
    chk("t1_dac_done", int'(dac_a), 19);
    tick(1);
    chk("t1_valid_delay", vtimes[$] - srise[$], S + N);
    tick(3);
    chk("t1_idle", int'(busy_a), 0);
    // endpoints
    foreach (ends[i]) begin
      vin_a = ends[i];
      go_a = 1;
      tick(3);
      go_a = 0;
      wait_valid("ep_valid_seen");
      chk("ep_result", int'(result_a), ends[i]);
      tick(4);
    end
    // continuous mode
    vin_a = 10;
    n0 = vtimes.size();
    go_a = 1;
    tick(40);
    go_a = 0;
    tick(25);
    chk("cont_busy_end", int'(busy_a), 0);
    chk("cont_enough", int'(vtimes.size() - n0 >= 4), 1);
    for (int i = n0 + 1; i < vtimes.size(); i++) chk("cont_period", vtimes[i] - vtimes[i-1], 9);
    chk("cont_result", int'(result_a), 10);
    // reset mid-CONVERT with result previously 19
    vin_a = 19;
    go_a = 1;
    tick(3);
    go_a = 0;
    wait_valid("rr_prev_valid");
    tick(3);
    chk("rr_prev_result", int'(result_a), 19);
    go_a = 1;
    tick(3);
    go_a = 0;
    for (int i = 0; i < 20 && !sample_a; i++) @(negedge clk);
    chk("rr_sample_on", int'(sample_a), 1);
    for (int i = 0; i < 20 && sample_a; i++) @(negedge clk);
    chk("rr_sample_off", int'(sample_a), 0);
    repeat (2) @(negedge clk);
    chk("rr_in_convert", int'(busy_a), 1);
    #2;
    nv = vtimes.size();
    rst = 1;
    #1;
    chk("rr_result", int'(result_a), 0);
    chk("rr_dac", int'(dac_a), 0);
    chk("rr_sample", int'(sample_a), 0);
    chk("rr_valid", int'(valid_a), 0);
    chk("rr_busy", int'(busy_a), 0);
    tick(2);
    rst = 0;
    tick(15);
    chk("rr_stay_idle", int'(busy_a), 0);
    chk("rr_no_valid", vtimes.size(), nv);
    // one-cycle go glitch, SAMPLE_CYCLES=1
    nsb = 0; nvb = 0;
    vin_b = 13;
    go_b = 1;
    tick(1);
    go_b = 0;
    tick(20);
    chk("g_sample_cycles", nsb, 1);
    chk("g_valid_count", nvb, 1);
    chk("g_valid_delay", tv_b - tr_b, SB + N);
    chk("g_result", rb, 13);
    chk("g_idle", int'(busy_b), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
